// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants and types for the instruction fetch stage
package instr_fetch_pkg;

  // Instruction-cycle phases as produced by clockReset
  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  // OPR values of the two-word instruction classes
  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;

  typedef enum logic {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } fetch_state_e;

  // How the jump target is formed: full 12-bit from OPA, or same-page from PC+1
  typedef enum logic [1:0] {
    JSEL_NONE = 2'd0,
    JSEL_FULL = 2'd1,
    JSEL_PAGE = 2'd2
  } jump_sel_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM-side inputs and decoder-side outputs of the fetch stage
interface instr_fetch_if;
  logic [2:0]  cycle;
  logic [3:0]  romData;
  logic [11:0] pcAddr;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  operand;
  logic        twoWord;
  logic        fetchPhase;
  logic        instrValid;
  logic [11:0] jumpAddr;

  modport master (
    output cycle, romData, pcAddr,
    input  opr, opa, operand, twoWord, fetchPhase, instrValid, jumpAddr
  );

  modport slave (
    input  cycle, romData, pcAddr,
    output opr, opa, operand, twoWord, fetchPhase, instrValid, jumpAddr
  );
endinterface

// File: rtl/two_word_detect.sv
// rtl/two_word_detect.sv - classifies a first word as one- or two-word and picks the jump form
module two_word_detect
  import instr_fetch_pkg::*;
(
  input  logic [3:0] opr_i,
  input  logic [3:0] opa_i,
  output logic       two_word_o,
  output jump_sel_e  jump_sel_o
);

  // FIM and SRC share OPR=2; only OPA bit 0 tells them apart
  always_comb begin
    two_word_o = 1'b0;
    jump_sel_o = JSEL_NONE;
    case (opr_i)
      OPR_JCN, OPR_ISZ: begin
        two_word_o = 1'b1;
        jump_sel_o = JSEL_PAGE;
      end
      OPR_JUN, OPR_JMS: begin
        two_word_o = 1'b1;
        jump_sel_o = JSEL_FULL;
      end
      OPR_FIM_SRC: two_word_o = ((opa_i & 4'b0001) == 4'b0000);
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - assembles ROM nibbles into one- or two-word instructions
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);

  fetch_state_e state_q;
  logic [3:0]   shadow_q;
  logic [3:0]   opr_q;
  logic [3:0]   opa_q;
  logic [7:0]   operand_q;
  logic         two_word_q;
  logic         valid_q;
  logic [11:0]  jump_q;

  logic [3:0]   det_opr;
  logic [3:0]   det_opa;
  logic         det_two;
  jump_sel_e    det_sel;
  logic [11:0]  jump_d;

  // In FETCH1 the decode looks at the word arriving now; in FETCH2 at the committed first word
  assign det_opr = (state_q == FETCH1) ? shadow_q    : opr_q;
  assign det_opa = (state_q == FETCH1) ? bus.romData : opa_q;

  two_word_detect u_detect (
    .opr_i      (det_opr),
    .opa_i      (det_opa),
    .two_word_o (det_two),
    .jump_sel_o (det_sel)
  );

  // Jump target from the second word; same-page jumps take the page of PC+1 (12-bit wrap)
  always_comb begin
    jump_d = 12'h000;
    case (det_sel)
      JSEL_FULL: jump_d = {opa_q, shadow_q, bus.romData};
      JSEL_PAGE: jump_d = ((bus.pcAddr + 12'd1) & 12'hF00) | {4'h0, shadow_q, bus.romData};
      default:   jump_d = 12'h000;
    endcase
  end

  // Fetch FSM: shadow OPR at M1, commit at M2, drop valid at X3; reset wins over all captures
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH1;
      shadow_q   <= 4'h0;
      opr_q      <= 4'h0;
      opa_q      <= 4'h0;
      operand_q  <= 8'h00;
      two_word_q <= 1'b0;
      valid_q    <= 1'b0;
      jump_q     <= 12'h000;
    end else begin
      if (bus.cycle == CYC_M1) begin
        shadow_q <= bus.romData;
      end
      if (bus.cycle == CYC_X3) begin
        valid_q <= 1'b0;
      end
      if (bus.cycle == CYC_M2) begin
        case (state_q)
          FETCH1: begin
            opr_q      <= shadow_q;
            opa_q      <= bus.romData;
            two_word_q <= det_two;
            operand_q  <= 8'h00;
            if (det_two) begin
              state_q <= FETCH2;
            end else begin
              valid_q <= 1'b1;
            end
          end
          FETCH2: begin
            operand_q <= {shadow_q, bus.romData};
            jump_q    <= jump_d;
            valid_q   <= 1'b1;
            state_q   <= FETCH1;
          end
        endcase
      end
    end
  end

  assign bus.opr        = opr_q;
  assign bus.opa        = opa_q;
  assign bus.operand    = operand_q;
  assign bus.twoWord    = two_word_q;
  assign bus.fetchPhase = (state_q == FETCH2);
  assign bus.instrValid = valid_q;
  assign bus.jumpAddr   = jump_q;

endmodule
